// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with any depth >= 2, programmable almost-full/almost-empty levels and a high watermark.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through read data; the default build uses a registered read.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = $clog2(FIFO_DEPTH),
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      afull_lvl,
  input  logic [CNT_W-1:0]      aempty_lvl,
  input  logic                  wm_clr,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic [CNT_W-1:0]      max_count
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DM1_C    = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_ack_q, ovf_q, udf_q;
  logic             wr_acc, rd_acc;
  logic [CNT_W-1:0] af_thr, ae_thr;

  always_comb begin
    wr_acc   = wr_en & (count_q < DEPTH_C);
    rd_acc   = rd_en & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc)
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    if (rd_acc)
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (wm_clr)
      max_d = count_d;
    else if (count_d > max_q)
      max_d = count_d;
    else
      max_d = max_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      max_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      max_q    <= max_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ack_q <= wr_acc;
      ovf_q    <= wr_en & ~wr_acc;
      udf_q    <= rd_en & ~rd_acc;
    end
  end

  // Storage is never reset; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc)
      mem_q[wr_ptr_q] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
`else
  logic [FIFO_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      data_q <= '0;
    else if (rd_acc)
      data_q <= mem_q[rd_ptr_q];
  end

  assign data_out = data_q;
`endif

  // Out-of-range levels fall back to the fixed DEPTH-1 / 1 thresholds.
  assign af_thr = (afull_lvl != '0 && afull_lvl <= DM1_C) ? afull_lvl : DM1_C;
  assign ae_thr = (aempty_lvl != '0 && aempty_lvl <= DM1_C) ? aempty_lvl : ONE_C;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= af_thr) & ~full;
  assign almostempty = (count_q <= ae_thr) & ~empty;

  assign count     = count_q;
  assign max_count = max_q;
  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: default depth 8 instance plus a depth 6 instance.
// Data checks follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [15:0] d8, q8;
  logic        we8, re8, wc8;
  logic [3:0]  afl8, ael8, cnt8, max8;
  logic [2:0]  wp8, rp8;
  logic        ack8, ovf8, udf8, full8, emp8, af8, ae8;

  sync_fifo_prog u8 (
    .clk(clk), .rst_n(rst_n), .data_in(d8), .wr_en(we8), .rd_en(re8),
    .afull_lvl(afl8), .aempty_lvl(ael8), .wm_clr(wc8),
    .data_out(q8), .wr_ack(ack8), .overflow(ovf8), .underflow(udf8),
    .full(full8), .empty(emp8), .almostfull(af8), .almostempty(ae8),
    .count(cnt8), .wr_ptr(wp8), .rd_ptr(rp8), .max_count(max8)
  );

  logic [15:0] d6, q6;
  logic        we6, re6;
  logic [3:0]  cnt6, max6;
  logic [2:0]  wp6, rp6;
  logic        ack6, ovf6, udf6, full6, emp6, af6, ae6;

  sync_fifo_prog #(.FIFO_DEPTH(6)) u6 (
    .clk(clk), .rst_n(rst_n), .data_in(d6), .wr_en(we6), .rd_en(re6),
    .afull_lvl(4'd0), .aempty_lvl(4'd0), .wm_clr(1'b0),
    .data_out(q6), .wr_ack(ack6), .overflow(ovf6), .underflow(udf6),
    .full(full6), .empty(emp6), .almostfull(af6), .almostempty(ae6),
    .count(cnt6), .wr_ptr(wp6), .rd_ptr(rp6), .max_count(max6)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [15:0] v);
    d8 = v; we8 = 1'b1;
    step();
    we8 = 1'b0;
  endtask

  task automatic pop8(input string tag, input logic [15:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, q8, exp);
    re8 = 1'b1; step(); re8 = 1'b0;
`else
    re8 = 1'b1; step(); re8 = 1'b0;
    chk(tag, q8, exp);
`endif
  endtask

  logic [15:0] q6m[$];
  logic [15:0] e6;
  logic [2:0]  wpm, rpm;
  logic [15:0] hold_exp;

  initial begin
    rst_n = 1'b0;
    d8 = '0; we8 = 0; re8 = 0; wc8 = 0; afl8 = '0; ael8 = '0;
    d6 = '0; we6 = 0; re6 = 0;
    step(); step();
    chk("rst_count", cnt8, 0);
    chk("rst_empty", emp8, 1);
    chk("rst_full", full8, 0);
    chk("rst_af", af8, 0);
    chk("rst_ae", ae8, 0);
    chk("rst_ack", ack8, 0);
    chk("rst_dout", q8, 0);
    chk("rst_max", max8, 0);
    rst_n = 1'b1;

    // fill to full
    for (int i = 0; i < 8; i++) begin
      push8(16'hA001 + 16'(i));
      chk($sformatf("fill_ack%0d", i), ack8, 1);
      chk($sformatf("fill_cnt%0d", i), cnt8, i + 1);
      chk($sformatf("fill_af%0d", i), af8, (i == 6) ? 1 : 0);
      chk($sformatf("fill_full%0d", i), full8, (i == 7) ? 1 : 0);
      chk($sformatf("fill_ae%0d", i), ae8, (i == 0) ? 1 : 0);
    end
    push8(16'hDEAD);
    chk("ovf_pulse", ovf8, 1);
    chk("ovf_ack", ack8, 0);
    chk("ovf_cnt", cnt8, 8);
    step();
    chk("ovf_drop", ovf8, 0);
    chk("max_full", max8, 8);

    // simultaneous rd/wr on full
`ifdef SYNC_FIFO_FWFT_EN
    chk("fullrw_head", q8, 16'hA001);
`endif
    d8 = 16'hBEEF; we8 = 1; re8 = 1;
    step();
    we8 = 0; re8 = 0;
`ifndef SYNC_FIFO_FWFT_EN
    chk("fullrw_dout", q8, 16'hA001);
`endif
    chk("fullrw_ovf", ovf8, 1);
    chk("fullrw_ack", ack8, 0);
    chk("fullrw_cnt", cnt8, 7);
    chk("fullrw_full", full8, 0);

    for (int i = 0; i < 7; i++)
      pop8($sformatf("drain%0d", i), 16'hA002 + 16'(i));
    chk("drain_empty", emp8, 1);
`ifdef SYNC_FIFO_FWFT_EN
    hold_exp = 16'h0000;
`else
    hold_exp = 16'hA008;
`endif
    re8 = 1; step(); re8 = 0;
    chk("udf_pulse", udf8, 1);
    chk("udf_hold", q8, hold_exp);
    step();
    chk("udf_drop", udf8, 0);

    // simultaneous rd/wr on empty
    d8 = 16'h5555; we8 = 1; re8 = 1;
    step();
    we8 = 0; re8 = 0;
    chk("emprw_udf", udf8, 1);
    chk("emprw_ack", ack8, 1);
    chk("emprw_cnt", cnt8, 1);
    chk("emprw_ae", ae8, 1);
    pop8("emprw_read", 16'h5555);
    chk("emprw_cnt0", cnt8, 0);

    // programmable thresholds
    afl8 = 4'd3; ael8 = 4'd2;
    for (int i = 0; i < 3; i++) begin
      push8(16'h0100 + 16'(i));
      chk($sformatf("thr_af%0d", i), af8, (i == 2) ? 1 : 0);
      chk($sformatf("thr_ae%0d", i), ae8, (i < 2) ? 1 : 0);
    end
    afl8 = 4'd0;
    step();
    chk("thr_af_dflt3", af8, 0);
    for (int i = 3; i < 7; i++) push8(16'h0100 + 16'(i));
    chk("thr_cnt7", cnt8, 7);
    chk("thr_af_dflt7", af8, 1);

    // watermark clear
    chk("wm_before", max8, 8);
    wc8 = 1; step(); wc8 = 0;
    chk("wm_clr7", max8, 7);
    pop8("wm_pop0", 16'h0100);
    pop8("wm_pop1", 16'h0101);
    chk("wm_hold", max8, 7);
    wc8 = 1; step(); wc8 = 0;
    chk("wm_clr5", max8, 5);

    // reset mid-operation with a pending write
    rst_n = 0; d8 = 16'h7777; we8 = 1;
    step();
    rst_n = 1; we8 = 0;
    chk("mrst_cnt", cnt8, 0);
    chk("mrst_empty", emp8, 1);
    chk("mrst_ack", ack8, 0);
    chk("mrst_max", max8, 0);
    chk("mrst_dout", q8, 0);

`ifdef SYNC_FIFO_FWFT_EN
    hold_exp = 16'h1234;
`else
    hold_exp = 16'h0000;
`endif
    push8(16'h1234);
    chk("single_wr_dout", q8, hold_exp);

    // depth 6: three ahead, then 20 paired rd/wr
    wpm = 0; rpm = 0;
    for (int i = 0; i < 3; i++) begin
      d6 = 16'hC000 + 16'(i); we6 = 1;
      q6m.push_back(d6);
      step();
      wpm = (wpm == 3'd5) ? 3'd0 : wpm + 3'd1;
    end
    for (int i = 0; i < 20; i++) begin
      e6 = q6m.pop_front();
      d6 = 16'hC003 + 16'(i);
      q6m.push_back(d6);
      we6 = 1; re6 = 1;
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("d6_data%0d", i), q6, e6);
      step();
`else
      step();
      chk($sformatf("d6_data%0d", i), q6, e6);
`endif
      wpm = (wpm == 3'd5) ? 3'd0 : wpm + 3'd1;
      rpm = (rpm == 3'd5) ? 3'd0 : rpm + 3'd1;
      chk($sformatf("d6_wp%0d", i), wp6, wpm);
      chk($sformatf("d6_rp%0d", i), rp6, rpm);
    end
    we6 = 0; re6 = 0;
    chk("d6_cnt", cnt6, 3);
    chk("d6_max", max6, 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO that replaces the fixed-threshold FIFO generation.
- Supports any depth of 2 or more, including non-power-of-two, with explicit pointer wrap.
- Almost-full and almost-empty thresholds are programmable at run time; a high-watermark register tracks peak occupancy.
- Keeps the existing flag, ack and error-pulse semantics so the current checker and UVM env bind to it unchanged.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (at least 1).
- FIFO_DEPTH, 8, number of entries (at least 2; need not be a power of two).
- PTR_W, $clog2(FIFO_DEPTH), pointer width (derived; do not override).
- CNT_W, $clog2(FIFO_DEPTH)+1, width of count and level ports (derived).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- afull_lvl  in  CNT_W  almost-full threshold (quasi-static).
- aempty_lvl  in  CNT_W  almost-empty threshold (quasi-static).
- wm_clr  in  1  clear the high watermark.
- data_out  out  FIFO_WIDTH  read data.
- wr_ack  out  1  registered: the previous-cycle write was accepted.
- overflow  out  1  registered: the previous-cycle write was rejected because the FIFO was full.
- underflow  out  1  registered: the previous-cycle read was rejected because the FIFO was empty.
- full, empty, almostfull, almostempty  out  1 each  occupancy flags, combinational from count.
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH.
- wr_ptr, rd_ptr  out  PTR_W each  internal pointers, exported for assertions.
- max_count  out  CNT_W  high watermark.

Behaviour:
- Reset: at a posedge with rst_n=0, all registers clear: count, wr_ptr, rd_ptr, max_count, data_out, wr_ack, overflow and underflow all go to 0. Flags then read full=0, empty=1, almostfull=0, almostempty=0. Memory contents are not cleared.
- Reset mid-operation discards all stored data. Requests in the reset cycle are ignored and produce no ack or error pulse.
- Write accept: wr_acc = wr_en & (count < FIFO_DEPTH). Data is stored at mem[wr_ptr], and wr_ptr advances, wrapping from FIFO_DEPTH-1 to 0.
- Read accept: rd_acc = rd_en & (count > 0). rd_ptr advances with the same wrap rule.
- Count update: count +1 when only wr_acc, -1 when only rd_acc, unchanged when both or neither.
- Full FIFO with wr_en and rd_en both high: the read is accepted and the write is rejected (overflow=1, count becomes DEPTH-1).
- Empty FIFO with wr_en and rd_en both high: the write is accepted and the read is rejected (underflow=1, count becomes 1).
- Pulses, each registered one cycle after the request and held for exactly one cycle, with no stickiness:
  - wr_ack = wr_acc
  - overflow = wr_en & ~wr_acc
  - underflow = rd_en & ~rd_acc
- Standard read timing: data_out is loaded with mem[rd_ptr] on the edge where rd_acc is true, so data is valid the cycle after rd_en. At all other times data_out holds its value.
- Flags:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almostfull = (count >= AF) & ~full
  - almostempty = (count <= AE) & ~empty
- Threshold legality:
  - AF = afull_lvl when 1 <= afull_lvl <= DEPTH-1; otherwise AF = DEPTH-1.
  - AE = aempty_lvl when 1 <= aempty_lvl <= DEPTH-1; otherwise AE = 1.
  - With the default values, the flags match the previous generation: almostfull at DEPTH-1, almostempty at 1.
- Watermark: each cycle, if the next count exceeds max_count, max_count takes the next count.
  - wm_clr=1 loads the next count instead.
  - wm_clr has lower priority than reset.
- Arithmetic: all pointer and count arithmetic is at CNT_W/PTR_W width with no silent truncation. Wrap is an explicit compare against DEPTH-1, not modulo-2^PTR_W.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through): data_out = empty ? 0 : mem[rd_ptr], combinational.
  - The head word is visible the cycle after it is written into an empty FIFO.
  - rd_acc pops the word, and the next word appears in the same cycle as the pointer update.
  - Flags, count, acks and error pulses are unchanged.
- Undefined: the standard registered-read timing described under Behaviour applies.

Test Plan:
- Reset, then write 0xA001..0xA008 (DEPTH=8) on consecutive cycles -> wr_ack high for 8 cycles. almostfull rises when count=7. full=1 when count=8. A 9th write gives overflow=1 for one cycle and count stays 8.
- Full FIFO, wr_en=rd_en=1 for one cycle -> data_out=0xA001 on the next cycle, overflow=1, wr_ack=0, count=7, full=0.
- Empty FIFO, wr_en=rd_en=1 with data 0x5555 -> underflow=1, wr_ack=1, count=1, almostempty=1. The following read returns 0x5555.
- DEPTH=6 override: 20 interleaved write/read pairs -> wr_ptr and rd_ptr sequence 0..5,0 with no pointer ever reaching 6. Data stays FIFO-ordered, and max_count equals the peak count.
- afull_lvl=3, aempty_lvl=2: fill to 3 -> almostfull=1 at count 3, almostempty=1 at counts 1-2 only. Then afull_lvl=0 -> almostfull switches to the count=7 default.
- Assert rst_n=0 for one cycle at count=5 with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0, max_count=0, data_out=0. With SYNC_FIFO_FWFT_EN defined, a single write of 0x1234 -> data_out=0x1234 the next cycle with no rd_en.
